// File: rtl/lut_eval_scheduler.sv
// Round-robin scheduler sharing one LUT evaluator among NREQ requesters,
// each with its own runtime-loadable INIT table. Result returned two cycles after accept.
module lut_eval_scheduler #(
  parameter int          NREQ         = 4,
  parameter int          LUT_WIDTH    = 4,
  parameter logic [15:0] INIT_DEFAULT = 16'h000E
) (
  input  logic                           C,
  input  logic                           R,
  input  logic [NREQ-1:0]                req_valid,
  input  logic [NREQ*LUT_WIDTH-1:0]      req_addr,
  output logic [NREQ-1:0]                req_ready,
  output logic [NREQ-1:0]                rsp_valid,
  output logic                           rsp_data,
  input  logic                           cfg_we,
  input  logic [$clog2(NREQ)-1:0]        cfg_sel,
  input  logic [(1 << LUT_WIDTH)-1:0]    cfg_init,
  output logic                           busy
);

  localparam int SEL_W = $clog2(NREQ);
  localparam int TBL_W = 1 << LUT_WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t               state, state_next;
  logic [SEL_W-1:0]     rr_ptr;
  logic [SEL_W-1:0]     idx;
  logic [LUT_WIDTH-1:0] addr;
  logic [TBL_W-1:0]     init_tbl [NREQ];

  logic                 grant_found;
  logic [SEL_W-1:0]     grant_idx;
  int                   cand;

  // Round-robin search starting at rr_ptr; the first valid requester wins.
  // NOTE: every signal written in an always_comb gets a default first so no latch is inferred.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    for (int k = 0; k < NREQ; k++) begin
      cand = (int'(rr_ptr) + k) % NREQ;
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = SEL_W'(cand);
      end
    end
  end

  always_comb begin
    state_next = state;
    req_ready  = '0;
    rsp_valid  = '0;
    unique case (state)
      IDLE: begin
        // Grant is gated by R so no accept is advertised while reset is held.
        if (grant_found && !R) begin
          req_ready[grant_idx] = 1'b1;
          state_next           = EVAL;
        end
      end
      EVAL: state_next = RESP;
      RESP: begin
        rsp_valid[idx] = 1'b1;
        state_next     = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge C or posedge R) begin
    if (R) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      idx      <= '0;
      addr     <= '0;
      rsp_data <= 1'b0;
    end else begin
      state <= state_next;
      unique case (state)
        IDLE: begin
          if (grant_found) begin
            idx  <= grant_idx;
            addr <= req_addr[int'(grant_idx)*LUT_WIDTH +: LUT_WIDTH];
          end
        end
        EVAL: rsp_data <= init_tbl[idx][addr];
        RESP: rr_ptr <= (int'(idx) == NREQ-1) ? '0 : idx + 1'b1;
        default: ;
      endcase
    end
  end

  // A write landing on the EVAL edge is not seen by that evaluation: both sample pre-edge values.
  // NOTE: the INIT tables are a small register array that must come back to INIT_DEFAULT, so it is reset.
  always_ff @(posedge C or posedge R) begin
    if (R) begin
      for (int i = 0; i < NREQ; i++) init_tbl[i] <= INIT_DEFAULT[TBL_W-1:0];
    end else if (cfg_we && (int'(cfg_sel) < NREQ)) begin
      init_tbl[cfg_sel] <= cfg_init;
    end
  end

endmodule

// File: tb/tb_lut_eval_scheduler.sv
// Self-checking bench for lut_eval_scheduler: vector table, hand-written corner
// sequences, and randomized transactions against a transaction-level model.
module tb_lut_eval_scheduler;

  logic        C = 1'b0;
  logic        R = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [15:0] req_addr = '0;
  logic [3:0]  req_ready, rsp_valid;
  logic        rsp_data, busy;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_sel = '0;
  logic [15:0] cfg_init = '0;

  // Second instance: NREQ=5 makes out-of-range cfg_sel values representable; LUT_WIDTH=3.
  logic [4:0]  v5_valid = '0;
  logic [14:0] v5_addr = '0;
  logic [4:0]  v5_ready, v5_rsp_valid;
  logic        v5_rsp_data, v5_busy;
  logic        v5_we = 1'b0;
  logic [2:0]  v5_sel = '0;
  logic [7:0]  v5_init = '0;

  int errors = 0;
  int checks = 0;
  logic exp_hold = 1'b0;

  always #5 C = ~C;

  lut_eval_scheduler #(.NREQ(4), .LUT_WIDTH(4), .INIT_DEFAULT(16'h000E)) u_dut (
    .C(C), .R(R), .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .cfg_we(cfg_we), .cfg_sel(cfg_sel),
    .cfg_init(cfg_init), .busy(busy)
  );

  lut_eval_scheduler #(.NREQ(5), .LUT_WIDTH(3), .INIT_DEFAULT(16'h000E)) u_dut5 (
    .C(C), .R(R), .req_valid(v5_valid), .req_addr(v5_addr), .req_ready(v5_ready),
    .rsp_valid(v5_rsp_valid), .rsp_data(v5_rsp_data), .cfg_we(v5_we), .cfg_sel(v5_sel),
    .cfg_init(v5_init), .busy(v5_busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    @(negedge C);
    R = 1'b1; req_valid = '0; cfg_we = 1'b0; v5_valid = '0; v5_we = 1'b0;
    #1;
    check("rst_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_busy", busy, 0);
    @(negedge C);
    R = 1'b0;
    exp_hold = 1'b0;
  endtask

  task automatic cfg_write(input logic [1:0] sel, input logic [15:0] init);
    @(negedge C);
    cfg_we = 1'b1; cfg_sel = sel; cfg_init = init;
    @(negedge C);
    cfg_we = 1'b0;
  endtask

  // One complete transaction: accept cycle, EVAL cycle, RESP cycle.
  // Optional config writes are presented in the accept and EVAL cycles.
  task automatic run_txn(input logic [3:0] mask, input logic [15:0] addrs,
                         input logic we0, input logic [1:0] sel0, input logic [15:0] init0,
                         input logic we1, input logic [1:0] sel1, input logic [15:0] init1,
                         input logic [3:0] exp_ready, input logic exp_data, input string name);
    @(negedge C);
    req_valid = mask; req_addr = addrs;
    cfg_we = we0; cfg_sel = sel0; cfg_init = init0;
    #1;
    check({name, "_ready"}, req_ready, exp_ready);
    check({name, "_idle_busy"}, busy, 0);
    check({name, "_hold_data"}, rsp_data, exp_hold);
    @(negedge C);
    req_valid = '0;
    cfg_we = we1; cfg_sel = sel1; cfg_init = init1;
    #1;
    check({name, "_eval_busy"}, busy, 1);
    check({name, "_eval_ready"}, req_ready, 0);
    check({name, "_eval_rsp"}, rsp_valid, 0);
    @(negedge C);
    cfg_we = 1'b0;
    #1;
    check({name, "_rsp_valid"}, rsp_valid, exp_ready);
    check({name, "_rsp_data"}, rsp_data, exp_data);
    exp_hold = exp_data;
  endtask

  task automatic run5(input int r, input logic [2:0] a, input logic exp_data);
    @(negedge C);
    v5_valid = 5'(1 << r); v5_addr = {5{a}};
    #1;
    check($sformatf("n5_ready_r%0d_a%0d", r, a), v5_ready, 1 << r);
    @(negedge C);
    v5_valid = '0;
    @(negedge C);
    #1;
    check($sformatf("n5_rsp_valid_r%0d_a%0d", r, a), v5_rsp_valid, 1 << r);
    check($sformatf("n5_rsp_data_r%0d_a%0d", r, a), v5_rsp_data, exp_data);
  endtask

  typedef struct {
    logic [3:0] mask;
    logic [3:0] addr;
    logic [3:0] exp_ready;
    logic       exp_data;
  } vec_t;

  vec_t vecs [10];

  // Transaction-level reference state.
  logic [15:0] m_tbl [4];
  int          m_rr;

  initial begin
    // INIT 0x000E: address 1..3 read 1, every other address reads 0.
    vecs[0] = '{4'b0001, 4'd1,  4'b0001, 1'b1};
    vecs[1] = '{4'b0001, 4'd0,  4'b0001, 1'b0};
    vecs[2] = '{4'b0001, 4'd4,  4'b0001, 1'b0};
    vecs[3] = '{4'b1111, 4'd2,  4'b0010, 1'b1};
    vecs[4] = '{4'b1111, 4'd3,  4'b0100, 1'b1};
    vecs[5] = '{4'b1111, 4'd15, 4'b1000, 1'b0};
    vecs[6] = '{4'b1111, 4'd1,  4'b0001, 1'b1};
    vecs[7] = '{4'b1001, 4'd2,  4'b1000, 1'b1};
    vecs[8] = '{4'b0110, 4'd5,  4'b0010, 1'b0};
    vecs[9] = '{4'b0010, 4'd3,  4'b0010, 1'b1};

    R = 1'b1;
    #12;
    R = 1'b0;

    do_reset();
    for (int i = 0; i < 10; i++)
      run_txn(vecs[i].mask, {4{vecs[i].addr}}, 1'b0, 2'd0, 16'h0, 1'b0, 2'd0, 16'h0,
              vecs[i].exp_ready, vecs[i].exp_data, $sformatf("vec%0d", i));

    // All requesters held: grants 0,1,2,3,0 three cycles apart.
    do_reset();
    @(negedge C);
    req_valid = 4'b1111; req_addr = '0;
    for (int cyc = 0; cyc < 15; cyc++) begin
      #1;
      check($sformatf("rr_ready_c%0d", cyc), req_ready,
            (cyc % 3 == 0) ? (1 << ((cyc / 3) % 4)) : 0);
      check($sformatf("rr_busy_c%0d", cyc), busy, (cyc % 3 != 0) ? 1 : 0);
      check($sformatf("rr_rsp_c%0d", cyc), rsp_valid,
            (cyc % 3 == 2) ? (1 << ((cyc / 3) % 4)) : 0);
      @(negedge C);
    end
    req_valid = '0;
    exp_hold = 1'b0;

    // Config write then read; write coincident with EVAL returns the old value.
    do_reset();
    cfg_write(2'd2, 16'h8000);
    run_txn(4'b0100, 16'hFFFF, 1'b0, 2'd0, 16'h0, 1'b0, 2'd0, 16'h0, 4'b0100, 1'b1, "cfg_new");
    do_reset();
    run_txn(4'b0100, 16'hFFFF, 1'b0, 2'd0, 16'h0, 1'b1, 2'd2, 16'h8000, 4'b0100, 1'b0, "cfg_eval_old");
    run_txn(4'b0100, 16'hFFFF, 1'b0, 2'd0, 16'h0, 1'b0, 2'd0, 16'h0, 4'b0100, 1'b1, "cfg_eval_next");

    // Reset during EVAL drops the request and restores tables and rr_ptr.
    do_reset();
    cfg_write(2'd0, 16'h0000);
    run_txn(4'b0010, 16'h1111, 1'b0, 2'd0, 16'h0, 1'b0, 2'd0, 16'h0, 4'b0010, 1'b1, "pre_rst");
    @(negedge C);
    req_valid = 4'b0100; req_addr = 16'h1111;
    #1;
    check("inflight_ready", req_ready, 4'b0100);
    @(negedge C);
    req_valid = '0;
    #1;
    check("inflight_eval_busy", busy, 1);
    R = 1'b1;
    #1;
    check("mid_rst_rsp", rsp_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_data", rsp_data, 0);
    @(negedge C);
    #1;
    check("mid_rst_no_rsp", rsp_valid, 0);
    R = 1'b0;
    exp_hold = 1'b0;
    run_txn(4'b1111, 16'h1111, 1'b0, 2'd0, 16'h0, 1'b0, 2'd0, 16'h0, 4'b0001, 1'b1, "post_rst");

    // Out-of-range cfg_sel on the 5-requester instance changes nothing.
    for (int s = 5; s < 8; s++) begin
      @(negedge C);
      v5_we = 1'b1; v5_sel = 3'(s); v5_init = 8'hFF;
      @(negedge C);
      v5_we = 1'b0;
    end
    for (int r = 0; r < 5; r++) begin
      run5(r, 3'd0, 1'b0);
      run5(r, 3'd1, 1'b1);
      run5(r, 3'd4, 1'b0);
    end
    @(negedge C);
    v5_we = 1'b1; v5_sel = 3'd4; v5_init = 8'h01;
    @(negedge C);
    v5_we = 1'b0;
    run5(4, 3'd0, 1'b1);
    run5(3, 3'd0, 1'b0);

    // Randomized transactions with config writes, against the model.
    do_reset();
    for (int i = 0; i < 4; i++) m_tbl[i] = 16'h000E;
    m_rr = 0;
    for (int n = 0; n < 60; n++) begin
      logic [3:0]  mask;
      logic [15:0] addrs, init0, init1;
      logic        we0, we1, exp_d;
      logic [1:0]  sel0, sel1;
      logic [3:0]  a;
      int          g;
      mask  = 4'($urandom_range(1, 15));
      addrs = 16'($urandom);
      we0   = 1'($urandom_range(0, 1));
      we1   = 1'($urandom_range(0, 1));
      sel0  = 2'($urandom_range(0, 3));
      sel1  = 2'($urandom_range(0, 3));
      init0 = 16'($urandom);
      init1 = 16'($urandom);
      g = -1;
      for (int k = 0; k < 4; k++)
        if (g < 0 && mask[(m_rr + k) % 4]) g = (m_rr + k) % 4;
      if (we0) m_tbl[sel0] = init0;
      a     = addrs[g*4 +: 4];
      exp_d = m_tbl[g][a];
      if (we1) m_tbl[sel1] = init1;
      m_rr = (g + 1) % 4;
      run_txn(mask, addrs, we0, sel0, init0, we1, sel1, init1, 4'(1 << g), exp_d,
              $sformatf("rnd%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
